sensor_conditioner: RTL and testbench

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

---
 rtl/sensor_conditioner_pkg.sv | 24 ++
 rtl/sensor_conditioner_if.sv | 29 ++
 rtl/sensor_conditioner_lane_debounce.sv | 58 +++++
 rtl/sensor_conditioner.sv | 130 +++++++++++++
 tb/tb_sensor_conditioner.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_conditioner_pkg
//  Description : Shared lane/age constants and types for sensor_conditioner.
//  Revision    : 1.0  initial release
// ============================================================================
package sensor_conditioner_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;
    localparam int AGE_W     = 8;

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [AGE_W-1:0]  age_t;

    localparam age_t AGE_MAX = 8'd255;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_conditioner_if
//  Description : Lane sensor, service-clear and priority signals.
//  Revision    : 1.0  initial release
// ============================================================================
interface sensor_conditioner_if;
    import sensor_conditioner_pkg::*;

    logic [NUM_LANES-1:0] T_RAW;
    logic                 CLEAR;
    lane_t                CLEAR_SIDE;
    logic [NUM_LANES-1:0] T_CLEAN;
    logic [NUM_LANES-1:0] REQ;
    logic                 PRIO_VALID;
    lane_t                PRIO_SIDE;

    modport slave (
        input  T_RAW, CLEAR, CLEAR_SIDE,
        output T_CLEAN, REQ, PRIO_VALID, PRIO_SIDE
    );

    modport master (
        output T_RAW, CLEAR, CLEAR_SIDE,
        input  T_CLEAN, REQ, PRIO_VALID, PRIO_SIDE
    );

endinterface
`default_nettype wire

// File: rtl/sensor_conditioner_lane_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : lane_debounce
//  Description : Per-lane 2-flop synchronizer, sample-tick debouncer, clean level.
//  Revision    : 1.0  initial release
// ============================================================================
module lane_debounce
    import sensor_conditioner_pkg::*;
#(
    parameter int DB_COUNT = 20
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_sample_tick,
    input  wire logic i_raw,
    output logic      o_clean
);

    localparam int                CNT_W     = cnt_width(DB_COUNT);
    localparam logic [CNT_W-1:0]  c_DB_LAST = CNT_W'(DB_COUNT - 1);

    logic [1:0]       sync_q,  sync_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             clean_q, clean_d;

    always_comb begin
        sync_d  = {sync_q[0], i_raw};
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (i_sample_tick) begin
            if (sync_q[1] == clean_q) begin
                cnt_d = '0;
            end else if (cnt_q == c_DB_LAST) begin
                // DB_COUNT-th consecutive differing sample accepts the new level.
                clean_d = ~clean_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign o_clean = clean_q;

endmodule
`default_nettype wire

// File: rtl/sensor_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_conditioner
//  Description : Debounced lane occupancy, latched service requests, oldest-first
//                lane priority.
//  Revision    : 1.0  initial release
// ============================================================================
module sensor_conditioner
    import sensor_conditioner_pkg::*;
#(
    parameter int SAMPLE_DIV = 100000,
    parameter int DB_COUNT   = 20,
    parameter int AGE_DIV    = 1000
) (
    input  wire logic          CLK_100MHZ,
    input  wire logic          RESET,
    sensor_conditioner_if.slave bus
);

    localparam int                  PRESC_W      = cnt_width(SAMPLE_DIV);
    localparam int                  AGEDIV_W     = cnt_width(AGE_DIV);
    localparam logic [PRESC_W-1:0]  c_PRESC_LAST = PRESC_W'(SAMPLE_DIV - 1);
    localparam logic [AGEDIV_W-1:0] c_AGE_LAST   = AGEDIV_W'(AGE_DIV - 1);

    logic [PRESC_W-1:0]   presc_q,      presc_d;
    logic [AGEDIV_W-1:0]  age_div_q,    age_div_d;
    logic                 sample_tick,  age_tick;
    logic [NUM_LANES-1:0] t_clean;
    logic [NUM_LANES-1:0] clean_prev_q, clean_prev_d;
    logic [NUM_LANES-1:0] req_q,        req_d;
    logic [NUM_LANES-1:0] clear_hit;
    age_t                 age_q [NUM_LANES];
    age_t                 age_d [NUM_LANES];
    logic                 prio_valid_q, prio_valid_d;
    lane_t                prio_side_q,  prio_side_d;
    logic                 best_found;
    lane_t                best_side;
    age_t                 best_age;

    always_comb begin
        sample_tick = (presc_q == c_PRESC_LAST);
        presc_d     = sample_tick ? '0 : presc_q + PRESC_W'(1);
        age_tick    = sample_tick && (age_div_q == c_AGE_LAST);
        age_div_d   = age_div_q;
        if (sample_tick) begin
            age_div_d = age_tick ? '0 : age_div_q + AGEDIV_W'(1);
        end
    end

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            lane_debounce #(
                .DB_COUNT (DB_COUNT)
            ) u_lane_debounce (
                .clk           (CLK_100MHZ),
                .rst           (RESET),
                .i_sample_tick (sample_tick),
                .i_raw         (bus.T_RAW[g]),
                .o_clean       (t_clean[g])
            );
        end
    endgenerate

    // Clear beats a simultaneous rising edge; the lane re-arms only on a later edge.
    always_comb begin
        clean_prev_d = t_clean;
        for (int i = 0; i < NUM_LANES; i++) begin
            clear_hit[i] = bus.CLEAR && (bus.CLEAR_SIDE == LANE_W'(i));
            req_d[i]     = req_q[i];
            if (clear_hit[i]) begin
                req_d[i] = 1'b0;
            end else if (t_clean[i] && !clean_prev_q[i]) begin
                req_d[i] = 1'b1;
            end
            age_d[i] = age_q[i];
            if (!req_q[i] || clear_hit[i]) begin
                age_d[i] = '0;
            end else if (age_tick && (age_q[i] != AGE_MAX)) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
        end
    end

    // Strict greater-than while scanning upward keeps ties on the lowest lane.
    always_comb begin
        best_found = 1'b0;
        best_side  = '0;
        best_age   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (req_q[i] && (!best_found || (age_q[i] > best_age))) begin
                best_found = 1'b1;
                best_side  = LANE_W'(i);
                best_age   = age_q[i];
            end
        end
        prio_valid_d = |req_q;
        prio_side_d  = best_found ? best_side : prio_side_q;
    end

    always_ff @(posedge CLK_100MHZ or posedge RESET) begin
        if (RESET) begin
            presc_q      <= '0;
            age_div_q    <= '0;
            clean_prev_q <= '0;
            req_q        <= '0;
            prio_valid_q <= 1'b0;
            prio_side_q  <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            presc_q      <= presc_d;
            age_div_q    <= age_div_d;
            clean_prev_q <= clean_prev_d;
            req_q        <= req_d;
            prio_valid_q <= prio_valid_d;
            prio_side_q  <= prio_side_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign bus.T_CLEAN    = t_clean;
    assign bus.REQ        = req_q;
    assign bus.PRIO_VALID = prio_valid_q;
    assign bus.PRIO_SIDE  = prio_side_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sensor_conditioner
//  Description : Event scoreboard bench for sensor_conditioner (small dividers).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sensor_conditioner;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic mon_en = 1'b0;
    logic [10:0] prev_vec = '0;
    int   last_evt = 0;

    typedef struct {
        string       tag;
        logic [10:0] vec;
        int          base;
        int          lo;
        int          hi;
    } exp_t;

    exp_t sb_q[$];

    sensor_conditioner_if bus_if();

    sensor_conditioner #(
        .SAMPLE_DIV (4),
        .DB_COUNT   (3),
        .AGE_DIV    (2)
    ) dut (
        .CLK_100MHZ (clk),
        .RESET      (rst),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [10:0] mk(input logic [3:0] tc, input logic [3:0] rq,
                                       input logic pv, input logic [1:0] ps);
        return {tc, rq, pv, ps};
    endfunction

    // base < 0: delay measured from the previous output event.
    task automatic expect_ev(input string tag, input logic [10:0] v,
                             input int base, input int lo, input int hi);
        exp_t e;
        e.tag = tag; e.vec = v; e.base = base; e.lo = lo; e.hi = hi;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk({tag, "_drain"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic do_clear(input logic [1:0] side);
        bus_if.CLEAR      = 1'b1;
        bus_if.CLEAR_SIDE = side;
        step();
        bus_if.CLEAR      = 1'b0;
    endtask

    // Every change of the output vector must match the next queued expectation.
    initial begin : monitor
        exp_t        e;
        int          dly;
        logic [10:0] cur;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = {bus_if.T_CLEAN, bus_if.REQ, bus_if.PRIO_VALID, bus_if.PRIO_SIDE};
                if (cur !== prev_vec) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_change", {21'd0, cur}, {21'd0, prev_vec});
                    end else begin
                        e   = sb_q.pop_front();
                        dly = (e.base < 0) ? (cyc - last_evt) : (cyc - e.base);
                        chk(e.tag, {21'd0, cur}, {21'd0, e.vec});
                        chk({e.tag, "_latency"}, {31'd0, (dly >= e.lo && dly <= e.hi)}, 32'd1);
                    end
                    last_evt = cyc;
                    prev_vec = cur;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst               = 1'b1;
        bus_if.T_RAW      = 4'b0000;
        bus_if.CLEAR      = 1'b0;
        bus_if.CLEAR_SIDE = 2'd0;
        wait_cycles(5);
        chk("rst_t_clean",    bus_if.T_CLEAN,    0);
        chk("rst_req",        bus_if.REQ,        0);
        chk("rst_prio_valid", bus_if.PRIO_VALID, 0);
        chk("rst_prio_side",  bus_if.PRIO_SIDE,  0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Quiet inputs: nothing may move.
        wait_cycles(100);
        chk("idle_outputs", {bus_if.T_CLEAN, bus_if.REQ, bus_if.PRIO_VALID, bus_if.PRIO_SIDE}, 0);

        // 8-cycle glitch spans only two sample ticks.
        bus_if.T_RAW = 4'b0100;
        wait_cycles(8);
        bus_if.T_RAW = 4'b0000;
        wait_cycles(40);
        chk("glitch_t_clean2", bus_if.T_CLEAN[2], 0);
        chk("glitch_req2",     bus_if.REQ[2],     0);

        // Lane 1 held: clean, then request, then priority, one cycle apart.
        expect_ev("l1_clean", mk(4'b0010, 4'b0000, 0, 2'd0), cyc, 11, 14);
        expect_ev("l1_req",   mk(4'b0010, 4'b0010, 0, 2'd0), -1, 1, 1);
        expect_ev("l1_prio",  mk(4'b0010, 4'b0010, 1, 2'd1), -1, 1, 1);
        bus_if.T_RAW = 4'b0010;
        drain("lane1_up", 40);

        step();
        expect_ev("l1_clr_req",  mk(4'b0010, 4'b0000, 1, 2'd1), cyc, 1, 1);
        expect_ev("l1_clr_prio", mk(4'b0010, 4'b0000, 0, 2'd1), -1, 1, 1);
        do_clear(2'd1);
        drain("lane1_clear", 10);

        step();
        expect_ev("l1_release", mk(4'b0000, 4'b0000, 0, 2'd1), cyc, 11, 14);
        bus_if.T_RAW = 4'b0000;
        drain("lane1_down", 40);

        // Lane 0 then lane 3 later: older lane 0 keeps priority.
        step();
        expect_ev("l0_clean", mk(4'b0001, 4'b0000, 0, 2'd1), cyc, 11, 14);
        expect_ev("l0_req",   mk(4'b0001, 4'b0001, 0, 2'd1), -1, 1, 1);
        expect_ev("l0_prio",  mk(4'b0001, 4'b0001, 1, 2'd0), -1, 1, 1);
        bus_if.T_RAW = 4'b0001;
        drain("lane0_up", 40);
        wait_cycles(30);
        expect_ev("l3_clean", mk(4'b1001, 4'b0001, 1, 2'd0), cyc, 11, 14);
        expect_ev("l3_req",   mk(4'b1001, 4'b1001, 1, 2'd0), -1, 1, 1);
        bus_if.T_RAW = 4'b1001;
        drain("lane3_up", 40);
        wait_cycles(5);
        chk("prio_oldest", bus_if.PRIO_SIDE, 0);

        expect_ev("l0_clr_req",  mk(4'b1001, 4'b1000, 1, 2'd0), cyc, 1, 1);
        expect_ev("l0_clr_prio", mk(4'b1001, 4'b1000, 1, 2'd3), -1, 1, 1);
        do_clear(2'd0);
        drain("lane0_clear", 10);

        // Clear lands in the same cycle as lane 2's set.
        step();
        expect_ev("l2_clean", mk(4'b1101, 4'b1000, 1, 2'd3), cyc, 11, 14);
        bus_if.T_RAW = 4'b1101;
        begin
            int n = 0;
            while (bus_if.T_CLEAN[2] !== 1'b1 && n < 30) begin
                @(negedge clk);
                n++;
            end
            #1;
            chk("l2_rise_seen", bus_if.T_CLEAN[2], 1);
        end
        do_clear(2'd2);
        wait_cycles(10);
        chk("clr_wins_req2", bus_if.REQ[2], 0);
        drain("lane2_race", 5);

        // Re-arm only on a fresh edge.
        expect_ev("l2_fall", mk(4'b1001, 4'b1000, 1, 2'd3), cyc, 11, 14);
        bus_if.T_RAW = 4'b1001;
        drain("lane2_down", 40);
        step();
        expect_ev("l2_reclean", mk(4'b1101, 4'b1000, 1, 2'd3), cyc, 11, 14);
        expect_ev("l2_rereq",   mk(4'b1101, 4'b1100, 1, 2'd3), -1, 1, 1);
        bus_if.T_RAW = 4'b1101;
        drain("lane2_rearm", 40);

        step();
        expect_ev("l3_clr_req",  mk(4'b1101, 4'b0100, 1, 2'd3), cyc, 1, 1);
        expect_ev("l3_clr_prio", mk(4'b1101, 4'b0100, 1, 2'd2), -1, 1, 1);
        do_clear(2'd3);
        drain("lane3_clear", 10);
        step();
        expect_ev("l2_clr_req",  mk(4'b1101, 4'b0000, 1, 2'd2), cyc, 1, 1);
        expect_ev("l2_clr_prio", mk(4'b1101, 4'b0000, 0, 2'd2), -1, 1, 1);
        do_clear(2'd2);
        drain("lane2_clear", 10);
        step();
        expect_ev("all_fall", mk(4'b0000, 4'b0000, 0, 2'd2), cyc, 11, 14);
        bus_if.T_RAW = 4'b0000;
        drain("all_down", 40);

        // Clear on an idle lane does nothing.
        do_clear(2'd1);
        wait_cycles(5);
        chk("noop_clear", {bus_if.REQ, bus_if.PRIO_VALID, bus_if.PRIO_SIDE}, {4'b0000, 1'b0, 2'd2});

        // Equal ages: lowest index wins.
        expect_ev("tie_clean", mk(4'b0110, 4'b0000, 0, 2'd2), cyc, 11, 14);
        expect_ev("tie_req",   mk(4'b0110, 4'b0110, 0, 2'd2), -1, 1, 1);
        expect_ev("tie_prio",  mk(4'b0110, 4'b0110, 1, 2'd1), -1, 1, 1);
        bus_if.T_RAW = 4'b0110;
        drain("tie_up", 40);
        wait_cycles(40);
        chk("tie_prio_hold", bus_if.PRIO_SIDE, 1);
        expect_ev("tie_clr1_req",  mk(4'b0110, 4'b0100, 1, 2'd1), cyc, 1, 1);
        expect_ev("tie_clr1_prio", mk(4'b0110, 4'b0100, 1, 2'd2), -1, 1, 1);
        do_clear(2'd1);
        drain("tie_clr1", 10);
        step();
        expect_ev("tie_clr2_req",  mk(4'b0110, 4'b0000, 1, 2'd2), cyc, 1, 1);
        expect_ev("tie_clr2_prio", mk(4'b0110, 4'b0000, 0, 2'd2), -1, 1, 1);
        do_clear(2'd2);
        drain("tie_clr2", 10);
        step();
        expect_ev("tie_fall", mk(4'b0000, 4'b0000, 0, 2'd2), cyc, 11, 14);
        bus_if.T_RAW = 4'b0000;
        drain("tie_down", 40);

        // Reset in the middle of a lane 3 debounce.
        step();
        bus_if.T_RAW = 4'b1000;
        wait_cycles(7);
        expect_ev("mid_reset", mk(4'b0000, 4'b0000, 0, 2'd0), cyc, 0, 1);
        rst = 1'b1;
        wait_cycles(2);
        drain("mid_reset", 3);
        chk("mid_reset_t_clean", bus_if.T_CLEAN, 0);
        expect_ev("post_rst_clean", mk(4'b1000, 4'b0000, 0, 2'd0), cyc, 11, 14);
        expect_ev("post_rst_req",   mk(4'b1000, 4'b1000, 0, 2'd0), -1, 1, 1);
        expect_ev("post_rst_prio",  mk(4'b1000, 4'b1000, 1, 2'd3), -1, 1, 1);
        rst = 1'b0;
        drain("post_reset", 40);

        // Hold lane 3 for >255 age ticks (8 cycles each).
        wait_cycles(300 * 8 + 20);
        chk("age_saturated", dut.age_q[3], 255);
        wait_cycles(10 * 8);
        chk("age_no_wrap",   dut.age_q[3], 255);
        chk("sat_prio_side", bus_if.PRIO_SIDE, 3);

        wait_cycles(5);
        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
